// File: rtl/arb_pkg.sv
// Shared constants and state type for the 8-lane round-robin arbiter/mux.
package arb_pkg;

    localparam int unsigned LANES = 8;
    localparam int unsigned SEL_W = 3;

    // Output register occupancy: EMPTY means out_valid = 0, FULL means out_valid = 1.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_pick8.sv
// Rotating first-one search: picks the first requesting lane strictly after
// last_grant, wrapping 7 -> 0. Purely combinational.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [LANES-1:0] req,
    input  logic [SEL_W-1:0] last_grant,
    output logic [LANES-1:0] grant,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] lane;

    // Scan offsets 1..8 from last_grant; the first requesting lane wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        lane  = '0;
        for (int unsigned k = 1; k <= LANES; k++) begin
            lane = last_grant + SEL_W'(k);
            if (!any && req[lane]) begin
                any         = 1'b1;
                grant[lane] = 1'b1;
                idx         = lane;
            end
        end
    end

endmodule : rr_pick8

// File: rtl/arb_mux8.sv
// Eight-lane round-robin arbiter feeding a single-entry output register.
// A lane is accepted whenever the output register is empty or being drained
// in the same cycle, giving one word per cycle under sustained demand.
module arb_mux8
    import arb_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic [LANES-1:0]        in_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [SEL_W-1:0] last_grant;
    logic [LANES-1:0] pick_grant;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             load_en;
    logic             lane_xfer;

    rr_pick8 u_pick (
        .req        (in_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    assign out_valid = (state == FULL);
    assign load_en   = !out_valid || out_ready;
    // Reset gates the grant so no lane transfer can occur in a reset cycle.
    assign lane_xfer = load_en && !rst && pick_any;
    assign in_ready  = (load_en && !rst) ? pick_grant : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: fill on lane transfer, drain on output transfer with no refill.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (lane_xfer) state_nxt = FULL;
            FULL:  if (out_ready && !lane_xfer) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Output word, source index and round-robin pointer update on lane transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_sel    <= '0;
            last_grant <= SEL_W'(LANES - 1);
        end else if (lane_xfer) begin
            out_data   <= in_data[int'(pick_idx) * DATA_W +: DATA_W];
            out_sel    <= pick_idx;
            last_grant <= pick_idx;
        end
    end

endmodule : arb_mux8

// File: tb/tb_arb_mux8.sv
// Directed self-checking bench for arb_mux8 with hand-computed expectations.
module tb_arb_mux8;
    import arb_pkg::*;

    localparam int unsigned DATA_W = 8;

    logic                    clk;
    logic                    rst;
    logic [LANES-1:0]        in_valid;
    logic [LANES*DATA_W-1:0] in_data;
    logic [LANES-1:0]        in_ready;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_ready;

    int unsigned n_checks;
    int unsigned n_errors;

    arb_mux8 #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane i carries 0x10 + i unless overridden.
    task automatic default_data();
        for (int i = 0; i < 8; i++) begin
            in_data[i*DATA_W +: DATA_W] = 8'h10 + 8'(i);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        in_data   = '0;
        default_data();

        // Reset state, with all lanes requesting during reset.
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'h00);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_sel", 32'(out_sel), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h00);

        // Full demand: lanes 0..7 then 0, one word per cycle.
        rst = 1'b0;
        #1;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("seq_in_ready_%0d", i), 32'(in_ready), 32'(8'h01 << (i % 8)));
            tick();
            check($sformatf("seq_out_valid_%0d", i), 32'(out_valid), 32'h1);
            check($sformatf("seq_out_sel_%0d", i), 32'(out_sel), 32'(i % 8));
            check($sformatf("seq_out_data_%0d", i), 32'(out_data), 32'(8'h10 + 8'(i % 8)));
        end

        // Load 0xA5 from lane 3, then stall the output for 5 cycles.
        in_data[3*DATA_W +: DATA_W] = 8'hA5;
        in_valid = 8'h08;
        tick();
        check("a5_out_data", 32'(out_data), 32'hA5);
        check("a5_out_sel", 32'(out_sel), 32'h3);
        out_ready = 1'b0;
        in_valid  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("stall_in_ready_%0d", i), 32'(in_ready), 32'h00);
            tick();
            check($sformatf("stall_valid_%0d", i), 32'(out_valid), 32'h1);
            check($sformatf("stall_data_%0d", i), 32'(out_data), 32'hA5);
            check($sformatf("stall_sel_%0d", i), 32'(out_sel), 32'h3);
        end
        // Release: next lane after 3 is 4.
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'h10);
        tick();
        check("release_sel", 32'(out_sel), 32'h4);
        check("release_data", 32'(out_data), 32'h14);
        default_data();

        // Set last_grant = 6, then requests on lanes 0 and 2: wrap to 0, then 2.
        in_valid = 8'h40;
        tick();
        check("lg6_sel", 32'(out_sel), 32'h6);
        in_valid = 8'b0000_0101;
        #1;
        check("wrap_in_ready", 32'(in_ready), 32'h01);
        tick();
        check("wrap_sel", 32'(out_sel), 32'h0);
        check("wrap_data", 32'(out_data), 32'h10);
        #1;
        check("next_in_ready", 32'(in_ready), 32'h04);
        tick();
        check("next_sel", 32'(out_sel), 32'h2);

        // Single lane 5 with 0x3C, then idle drains the register.
        in_data[5*DATA_W +: DATA_W] = 8'h3C;
        in_valid = 8'h20;
        tick();
        check("l5_valid", 32'(out_valid), 32'h1);
        check("l5_data", 32'(out_data), 32'h3C);
        check("l5_sel", 32'(out_sel), 32'h5);
        in_valid = 8'h00;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'h00);
        tick();
        check("idle_valid", 32'(out_valid), 32'h0);
        check("idle_data_kept", 32'(out_data), 32'h3C);
        check("idle_sel_kept", 32'(out_sel), 32'h5);
        default_data();

        // Reset while holding an undelivered word.
        in_valid  = 8'hFF;
        out_ready = 1'b0;
        tick();
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        check("pre_rst_sel", 32'(out_sel), 32'h6);
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        check("in_rst_in_ready", 32'(in_ready), 32'h00);
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_sel", 32'(out_sel), 32'h0);
        check("mid_rst_data", 32'(out_data), 32'h00);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'h01);
        tick();
        check("post_rst_sel", 32'(out_sel), 32'h0);
        check("post_rst_valid", 32'(out_valid), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_arb_mux8
